// File: rtl/vga_timing_gen.sv
// VGA raster timing source and DAC-side output stage.
// Counts pixels and lines and publishes them as pixelX/pixelY for the drawers.
// It delays blank and sync by PIPE_DELAY pixel ticks (legal range 0..3) so
// they line up with the colour coming back from the object mux.
// It then registers colour and timing together onto the pins.
// The first pixel_en tick after reset loads hCount=0, vCount=0 and raises
// startOfFrame. Until that tick, the raw timing reads as blank with no sync.
// Optional macro VGA_TEST_PATTERN_EN adds a test_pattern input. When it is
// high, the active area shows eight vertical colour bars instead of the mux
// colour.
module vga_timing_gen #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int PIPE_DELAY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pixel_en,
`ifdef VGA_TEST_PATTERN_EN
    input  logic        test_pattern,
`endif
    output logic [10:0] pixelX,
    output logic [10:0] pixelY,
    output logic        startOfFrame,
    input  logic [7:0]  redIn,
    input  logic [7:0]  greenIn,
    input  logic [7:0]  blueIn,
    output logic [7:0]  vgaR,
    output logic [7:0]  vgaG,
    output logic [7:0]  vgaB,
    output logic        vgaHS,
    output logic        vgaVS,
    output logic        vgaBlankN,
    output logic        vgaSyncN
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_ACT_L   = 11'(H_ACTIVE);
    localparam logic [10:0] H_LAST_L  = 11'(H_TOTAL - 1);
    localparam logic [10:0] HS_BEG_L  = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END_L  = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] V_ACT_L   = 11'(V_ACTIVE);
    localparam logic [10:0] V_LAST_L  = 11'(V_TOTAL - 1);
    localparam logic [10:0] VS_BEG_L  = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END_L  = 11'(V_ACTIVE + V_FP + V_SYNC);

    logic [10:0] h_count;
    logic [10:0] v_count;
    logic        primed;
    logic        h_last;
    logic        v_last;
    logic        sof;

    logic        raw_active;
    logic        raw_hs_n;
    logic        raw_vs_n;
    logic        del_active;
    logic        del_hs_n;
    logic        del_vs_n;

    logic [7:0]  pix_r;
    logic [7:0]  pix_g;
    logic [7:0]  pix_b;

    logic [7:0]  out_r;
    logic [7:0]  out_g;
    logic [7:0]  out_b;
    logic        out_hs_n;
    logic        out_vs_n;
    logic        out_blank_n;

    assign h_last = (h_count == H_LAST_L);
    assign v_last = (v_count == V_LAST_L);

    // Raster counters: the first tick after reset primes at (0,0), then the
    // counters step once per tick and wrap at the end of line and frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            h_count <= '0;
            v_count <= '0;
            primed  <= 1'b0;
        end else if (pixel_en) begin
            if (!primed) begin
                primed  <= 1'b1;
                h_count <= '0;
                v_count <= '0;
            end else if (h_last) begin
                h_count <= '0;
                v_count <= v_last ? 11'd0 : v_count + 11'd1;
            end else begin
                h_count <= h_count + 11'd1;
            end
        end
    end

    // Start-of-frame strobe: high for the single clk after the tick that
    // loads (0,0), and cleared on every other clk, including stalled ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            sof <= 1'b0;
        end else begin
            sof <= pixel_en && (!primed || (h_last && v_last));
        end
    end

    // Raw blank and sync decoded from the counters. These are forced inactive
    // until the first tick has primed the raster.
    always_comb begin
        raw_active = primed && (h_count < H_ACT_L) && (v_count < V_ACT_L);
        raw_hs_n   = !(primed && (h_count >= HS_BEG_L) && (h_count < HS_END_L));
        raw_vs_n   = !(primed && (v_count >= VS_BEG_L) && (v_count < VS_END_L));
    end

`ifdef VGA_TEST_PATTERN_EN
    localparam logic [10:0] BAR_W_L = 11'(H_ACTIVE / 8);
    logic [10:0] del_h;
    logic [2:0]  bar;
`endif

    generate
        if (PIPE_DELAY == 0) begin : g_bypass
            assign del_active = raw_active;
            assign del_hs_n   = raw_hs_n;
            assign del_vs_n   = raw_vs_n;
`ifdef VGA_TEST_PATTERN_EN
            assign del_h      = h_count;
`endif
        end else begin : g_pipe
            logic [PIPE_DELAY-1:0] act_sr;
            logic [PIPE_DELAY-1:0] hs_sr;
            logic [PIPE_DELAY-1:0] vs_sr;

            // Alignment shift register for blank and sync, one stage per tick.
            always_ff @(posedge clk) begin
                if (reset) begin
                    act_sr <= '0;
                    hs_sr  <= '1;
                    vs_sr  <= '1;
                end else if (pixel_en) begin
                    act_sr[0] <= raw_active;
                    hs_sr[0]  <= raw_hs_n;
                    vs_sr[0]  <= raw_vs_n;
                    for (int i = 1; i < PIPE_DELAY; i++) begin
                        act_sr[i] <= act_sr[i-1];
                        hs_sr[i]  <= hs_sr[i-1];
                        vs_sr[i]  <= vs_sr[i-1];
                    end
                end
            end

            assign del_active = act_sr[PIPE_DELAY-1];
            assign del_hs_n   = hs_sr[PIPE_DELAY-1];
            assign del_vs_n   = vs_sr[PIPE_DELAY-1];

`ifdef VGA_TEST_PATTERN_EN
            logic [10:0] h_sr [PIPE_DELAY];

            // Delayed horizontal position, used only to pick the test bar.
            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int i = 0; i < PIPE_DELAY; i++) h_sr[i] <= '0;
                end else if (pixel_en) begin
                    h_sr[0] <= h_count;
                    for (int i = 1; i < PIPE_DELAY; i++) h_sr[i] <= h_sr[i-1];
                end
            end

            assign del_h = h_sr[PIPE_DELAY-1];
`endif
        end
    endgenerate

    // Colour source: the mux colour, or the test bars when they are selected.
    always_comb begin
        pix_r = redIn;
        pix_g = greenIn;
        pix_b = blueIn;
`ifdef VGA_TEST_PATTERN_EN
        bar = 3'(del_h / BAR_W_L);
        if (test_pattern) begin
            pix_r = bar[2] ? 8'hFF : 8'h00;
            pix_g = bar[1] ? 8'hFF : 8'h00;
            pix_b = bar[0] ? 8'hFF : 8'h00;
        end
`endif
    end

    // Output register: captures colour and the delayed timing together, and
    // forces black whenever the delayed position is outside the active area.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_r       <= '0;
            out_g       <= '0;
            out_b       <= '0;
            out_hs_n    <= 1'b1;
            out_vs_n    <= 1'b1;
            out_blank_n <= 1'b0;
        end else if (pixel_en) begin
            out_r       <= del_active ? pix_r : 8'h00;
            out_g       <= del_active ? pix_g : 8'h00;
            out_b       <= del_active ? pix_b : 8'h00;
            out_hs_n    <= del_hs_n;
            out_vs_n    <= del_vs_n;
            out_blank_n <= del_active;
        end
    end

    assign pixelX       = h_count;
    assign pixelY       = v_count;
    assign startOfFrame = sof;
    assign vgaR         = out_r;
    assign vgaG         = out_g;
    assign vgaB         = out_b;
    assign vgaHS        = out_hs_n;
    assign vgaVS        = out_vs_n;
    assign vgaBlankN    = out_blank_n;
    assign vgaSyncN     = 1'b0;

endmodule
